// File: rtl/pic_pkg.sv
// ----------------------------------------------------------------------------
// pic_pkg
// Shared types, constants and bit helpers for the 8259A-compatible
// interrupt-acknowledge sequencer.
//   ack_state_t        : acknowledge / poll sequencer states
//   PIC_SPURIOUS_LEVEL : level reported when an acknowledge finds no winner
//   rotate_right8/left8: 8-bit rotations used to map levels into priority order
//   onehot_to_level    : one-hot vector -> 3-bit level
//   level_to_onehot    : 3-bit level -> one-hot vector
// ----------------------------------------------------------------------------
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK1,
        ST_ACK1_HI,
        ST_ACK2,
        ST_POLL
    } ack_state_t;

    localparam logic [2:0] PIC_SPURIOUS_LEVEL = 3'd7;

    // result[i] = x[(i + n) mod 8]
    function automatic logic [7:0] rotate_right8(input logic [7:0] x, input logic [2:0] n);
        return 8'({x, x} >> n);
    endfunction

    // result[i] = x[(i - n) mod 8]
    function automatic logic [7:0] rotate_left8(input logic [7:0] x, input logic [2:0] n);
        return rotate_right8(x, 3'd0 - n);
    endfunction

    function automatic logic [2:0] onehot_to_level(input logic [7:0] oh);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) lvl = 3'(i);
        end
        return lvl;
    endfunction

    function automatic logic [7:0] level_to_onehot(input logic [2:0] lvl);
        return 8'b1 << lvl;
    endfunction

endpackage

// File: rtl/pic_ack_sequencer_if.sv
// ----------------------------------------------------------------------------
// pic_ack_sequencer_if
// Bundles the request, command, acknowledge and data-bus signals of the
// sequencer.
//   slave  : the sequencer (consumes requests/commands, drives int/ISR/bus)
//   master : the surrounding PIC logic / CPU side
// ----------------------------------------------------------------------------
interface pic_ack_sequencer_if;

    logic       inta_n;
    logic [7:0] irr;
    logic [7:0] imr;
    logic       special_mask_mode;
    logic       auto_eoi;
    logic       auto_rotate;
    logic [4:0] vector_base;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       rot_valid;
    logic [2:0] rot_level;
    logic       poll_cmd;
    logic       poll_read;

    logic       int_out;
    logic [7:0] isr;
    logic [7:0] clear_irr;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output inta_n, irr, imr, special_mask_mode, auto_eoi, auto_rotate,
               vector_base, eoi_valid, eoi_specific, eoi_level, rot_valid,
               rot_level, poll_cmd, poll_read,
        input  int_out, isr, clear_irr, data_out, data_oe
    );

    modport slave (
        input  inta_n, irr, imr, special_mask_mode, auto_eoi, auto_rotate,
               vector_base, eoi_valid, eoi_specific, eoi_level, rot_valid,
               rot_level, poll_cmd, poll_read,
        output int_out, isr, clear_irr, data_out, data_oe
    );

endinterface

// File: rtl/pic_priority_resolver.sv
// ----------------------------------------------------------------------------
// pic_priority_resolver
// Combinational priority pick. Priority runs from lowest+1 (highest) round to
// lowest. Returns the highest-priority bit of req that sits strictly above
// every set bit of isr_eff.
//   req     in  8  candidate bits
//   isr_eff in  8  in-service bits that block equal and lower levels
//   lowest  in  3  current lowest-priority level
//   valid   out 1  a qualifying bit exists
//   level   out 3  its level (0 when none)
// ----------------------------------------------------------------------------
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] req,
    input  logic [7:0] isr_eff,
    input  logic [2:0] lowest,
    output logic       valid,
    output logic [2:0] level
);

    logic [2:0] start;
    logic [7:0] req_r;
    logic [7:0] isr_r;
    logic [7:0] win_r;
    logic       blocked;

    assign start = lowest + 3'd1;

    // Rotate so bit 0 is the highest priority, scan upward, rotate back.
    // NOTE: every variable gets a default before the scan so no path leaves it
    // unassigned (no latch); blocking '=' lets the loop see its own updates.
    always_comb begin
        req_r   = rotate_right8(req, start);
        isr_r   = rotate_right8(isr_eff, start);
        win_r   = 8'h00;
        blocked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            // An in-service bit blocks its own level as well as lower ones.
            if (isr_r[i]) blocked = 1'b1;
            if (!blocked && req_r[i] && (win_r == 8'h00)) win_r[i] = 1'b1;
        end
        valid = |win_r;
        level = onehot_to_level(rotate_left8(win_r, start));
    end

endmodule

// File: rtl/pic_ack_sequencer.sv
// ----------------------------------------------------------------------------
// pic_ack_sequencer
// 8086-mode interrupt-acknowledge sequencer and priority arbiter for an
// 8259A-compatible PIC. Arbitrates irr & ~imr under fixed/rotating priority,
// drives int_out, runs the two-pulse INTA and OCW3 poll sequences and owns
// the ISR (normal, specific and automatic EOI).
//   SYNC_STAGES      synchronizer depth for inta_n (>= 2)
//   clk              system clock
//   reset            synchronous, active-high reset
//   bus (slave)      requests, mask, commands, INTA pin, and outputs
//                    int_out / isr / clear_irr / data_out / data_oe
// ----------------------------------------------------------------------------
module pic_ack_sequencer
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    pic_ack_sequencer_if.slave bus
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   inta_prev_q;
    logic                   inta_fall;
    logic                   inta_rise;

    ack_state_t state_q, state_d;
    logic [2:0] lowest_q, lowest_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] ack_level_q, ack_level_d;
    logic       spurious_q, spurious_d;
    logic       poll_valid_q, poll_valid_d;
    logic [2:0] poll_level_q, poll_level_d;
    logic       int_out_q, int_out_d;
    logic [7:0] clear_irr_q, clear_irr_d;

    logic [7:0] isr_set, isr_clr;
    logic       ack_rot, eoi_rot;
    logic [2:0] eoi_rot_level;
    logic       data_oe;
    logic [7:0] data_out;

    logic [7:0] isr_eff;
    logic       win_valid, isr_top_valid;
    logic [2:0] win_level, isr_top_level;

    // In special mask mode a masked in-service level no longer shields lower ones.
    assign isr_eff = bus.special_mask_mode ? (isr_q & ~bus.imr) : isr_q;

    pic_priority_resolver u_winner (
        .req     (bus.irr & ~bus.imr),
        .isr_eff (isr_eff),
        .lowest  (lowest_q),
        .valid   (win_valid),
        .level   (win_level)
    );

    // Highest-priority in-service level, target of a non-specific EOI.
    pic_priority_resolver u_isr_top (
        .req     (isr_q),
        .isr_eff (8'h00),
        .lowest  (lowest_q),
        .valid   (isr_top_valid),
        .level   (isr_top_level)
    );

    assign inta_fall = inta_prev_q & ~sync_q[SYNC_STAGES-1];
    assign inta_rise = ~inta_prev_q & sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d       = state_q;
        ack_level_d   = ack_level_q;
        spurious_d    = spurious_q;
        poll_valid_d  = poll_valid_q;
        poll_level_d  = poll_level_q;
        isr_set       = 8'h00;
        isr_clr       = 8'h00;
        clear_irr_d   = 8'h00;
        ack_rot       = 1'b0;
        eoi_rot       = 1'b0;
        eoi_rot_level = isr_top_level;
        data_oe       = 1'b0;
        data_out      = 8'h00;

        case (state_q)
            ST_IDLE: begin
                // An INTA falling edge takes precedence over a same-cycle poll.
                if (inta_fall) begin
                    state_d = ST_ACK1;
                    if (win_valid) begin
                        ack_level_d = win_level;
                        spurious_d  = 1'b0;
                        isr_set     = level_to_onehot(win_level);
                        clear_irr_d = level_to_onehot(win_level);
                    end else begin
                        ack_level_d = PIC_SPURIOUS_LEVEL;
                        spurious_d  = 1'b1;
                    end
                end else if (bus.poll_cmd) begin
                    state_d      = ST_POLL;
                    poll_valid_d = win_valid;
                    poll_level_d = win_valid ? win_level : 3'd0;
                end
            end
            ST_ACK1: begin
                if (inta_rise) state_d = ST_ACK1_HI;
            end
            ST_ACK1_HI: begin
                if (inta_fall) state_d = ST_ACK2;
            end
            ST_ACK2: begin
                data_oe  = 1'b1;
                data_out = {bus.vector_base, ack_level_q};
                if (inta_rise) begin
                    state_d = ST_IDLE;
                    if (bus.auto_eoi && !spurious_q) isr_clr = level_to_onehot(ack_level_q);
                    ack_rot = bus.auto_eoi && bus.auto_rotate;
                end
            end
            ST_POLL: begin
                if (bus.poll_read) begin
                    data_oe  = 1'b1;
                    data_out = {poll_valid_q, 4'b0000, poll_level_q};
                    if (poll_valid_q) begin
                        isr_set     = level_to_onehot(poll_level_q);
                        clear_irr_d = level_to_onehot(poll_level_q);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.eoi_valid) begin
            if (bus.eoi_specific) begin
                isr_clr = isr_clr | level_to_onehot(bus.eoi_level);
            end else if (isr_top_valid) begin
                isr_clr = isr_clr | level_to_onehot(isr_top_level);
                eoi_rot = bus.auto_rotate;
            end
        end

        // Explicit set-priority beats any automatic rotation.
        if (bus.rot_valid)  lowest_d = bus.rot_level;
        else if (eoi_rot)   lowest_d = eoi_rot_level;
        else if (ack_rot)   lowest_d = ack_level_q;
        else                lowest_d = lowest_q;

        // A clear only beats a set for the same bit in the same cycle.
        isr_d     = (isr_q | isr_set) & ~isr_clr;
        int_out_d = (state_d == ST_IDLE) && win_valid;
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '1;
            inta_prev_q  <= 1'b1;
            state_q      <= ST_IDLE;
            lowest_q     <= 3'd7;
            isr_q        <= 8'h00;
            ack_level_q  <= 3'd0;
            spurious_q   <= 1'b0;
            poll_valid_q <= 1'b0;
            poll_level_q <= 3'd0;
            int_out_q    <= 1'b0;
            clear_irr_q  <= 8'h00;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.inta_n};
            inta_prev_q  <= sync_q[SYNC_STAGES-1];
            state_q      <= state_d;
            lowest_q     <= lowest_d;
            isr_q        <= isr_d;
            ack_level_q  <= ack_level_d;
            spurious_q   <= spurious_d;
            poll_valid_q <= poll_valid_d;
            poll_level_q <= poll_level_d;
            int_out_q    <= int_out_d;
            clear_irr_q  <= clear_irr_d;
        end
    end

    assign bus.int_out   = int_out_q;
    assign bus.isr       = isr_q;
    assign bus.clear_irr = clear_irr_q;
    assign bus.data_out  = data_out;
    assign bus.data_oe   = data_oe;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pic_ack_sequencer
// Directed bench for pic_ack_sequencer. Expected bus words and clear_irr
// pulses are queued when stimulus is issued; a separate monitor pops and
// compares them whenever the DUT drives the bus or pulses clear_irr.
// ----------------------------------------------------------------------------
module tb_pic_ack_sequencer;

    localparam int SYNC_STAGES = 2;
    localparam int PHASE       = SYNC_STAGES + 3;

    logic clk = 1'b0;
    logic reset;

    pic_ack_sequencer_if bus ();

    pic_ack_sequencer #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_data_q[$];
    logic [7:0] exp_clear_q[$];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%02h expected=%02h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Monitor: compares each new bus drive and each clear_irr pulse.
    initial begin
        logic oe_prev;
        oe_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                oe_prev = 1'b0;
            end else begin
                if (bus.data_oe && !oe_prev) begin
                    if (exp_data_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL data_out: got=%02h expected=none", bus.data_out);
                    end else begin
                        check("data_out", bus.data_out, exp_data_q.pop_front());
                    end
                end
                if (bus.clear_irr != 8'h00) begin
                    if (exp_clear_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL clear_irr: got=%02h expected=none", bus.clear_irr);
                    end else begin
                        check("clear_irr", bus.clear_irr, exp_clear_q.pop_front());
                    end
                end
                oe_prev = bus.data_oe;
            end
        end
    end

    task automatic phase(input logic lvl);
        bus.inta_n = lvl;
        repeat (PHASE) step();
    endtask

    // Two INTA pulses; optionally a specific EOI lands in the same cycle the
    // first falling edge is acted on.
    task automatic do_ack(input logic inject_eoi, input logic [2:0] eoi_lvl);
        bus.inta_n = 1'b0;
        repeat (SYNC_STAGES) step();
        if (inject_eoi) begin
            bus.eoi_valid    = 1'b1;
            bus.eoi_specific = 1'b1;
            bus.eoi_level    = eoi_lvl;
        end
        step();
        bus.eoi_valid    = 1'b0;
        bus.eoi_specific = 1'b0;
        repeat (PHASE - SYNC_STAGES - 1) step();
        phase(1'b1);
        phase(1'b0);
        phase(1'b1);
        step();
    endtask

    task automatic pulse_eoi(input logic specific, input logic [2:0] lvl);
        bus.eoi_valid    = 1'b1;
        bus.eoi_specific = specific;
        bus.eoi_level    = lvl;
        step();
        bus.eoi_valid    = 1'b0;
        bus.eoi_specific = 1'b0;
    endtask

    task automatic pulse_rot(input logic [2:0] lvl);
        bus.rot_valid = 1'b1;
        bus.rot_level = lvl;
        step();
        bus.rot_valid = 1'b0;
    endtask

    task automatic do_poll();
        bus.poll_cmd = 1'b1;
        step();
        bus.poll_cmd = 1'b0;
        sample();
        check("poll_int_low", 8'(bus.int_out), 8'h00);
        step();
        bus.poll_read = 1'b1;
        step();
        bus.poll_read = 1'b0;
    endtask

    initial begin
        bit seen;
        reset                 = 1'b1;
        bus.inta_n            = 1'b1;
        bus.irr               = 8'h00;
        bus.imr               = 8'h00;
        bus.special_mask_mode = 1'b0;
        bus.auto_eoi          = 1'b0;
        bus.auto_rotate       = 1'b0;
        bus.vector_base       = 5'h10;
        bus.eoi_valid         = 1'b0;
        bus.eoi_specific      = 1'b0;
        bus.eoi_level         = 3'd0;
        bus.rot_valid         = 1'b0;
        bus.rot_level         = 3'd0;
        bus.poll_cmd          = 1'b0;
        bus.poll_read         = 1'b0;
        repeat (3) step();
        sample();
        check("reset_int_out",   8'(bus.int_out), 8'h00);
        check("reset_isr",       bus.isr,         8'h00);
        check("reset_clear_irr", bus.clear_irr,   8'h00);
        check("reset_data_out",  bus.data_out,    8'h00);
        check("reset_data_oe",   8'(bus.data_oe), 8'h00);
        step();
        reset = 1'b0;
        step();
        sample();
        check("idle_no_int", 8'(bus.int_out), 8'h00);

        // Basic acknowledge: IR2 wins over IR5, vector {10h, 2} = 82h.
        step();
        bus.irr = 8'h24;
        step();
        sample();
        check("basic_int_out", 8'(bus.int_out), 8'h01);
        exp_clear_q.push_back(8'h04);
        exp_data_q.push_back(8'h82);
        step();
        do_ack(1'b0, 3'd0);
        bus.irr = 8'h20;
        sample();
        check("basic_isr", bus.isr, 8'h04);
        step();
        step();
        sample();
        check("basic_ir5_blocked", 8'(bus.int_out), 8'h00);

        // Nesting with IR2 in service.
        step();
        bus.irr = 8'h10;
        step();
        step();
        sample();
        check("nest_lower_blocked", 8'(bus.int_out), 8'h00);
        step();
        bus.irr = 8'h12;
        step();
        sample();
        check("nest_higher_wins", 8'(bus.int_out), 8'h01);
        step();
        bus.irr = 8'h10;
        step();
        step();
        sample();
        check("nest_ir4_again_blocked", 8'(bus.int_out), 8'h00);
        step();
        bus.special_mask_mode = 1'b1;
        bus.imr               = 8'h04;
        step();
        sample();
        check("smm_ir4_wins", 8'(bus.int_out), 8'h01);
        step();
        bus.special_mask_mode = 1'b0;
        bus.imr               = 8'h00;
        bus.irr               = 8'h00;
        pulse_eoi(1'b1, 3'd2);
        sample();
        check("specific_eoi_isr", bus.isr, 8'h00);

        // AEOI + rotate on IR3, then IR4 outranks IR0.
        step();
        bus.auto_eoi    = 1'b1;
        bus.auto_rotate = 1'b1;
        bus.irr         = 8'h08;
        step();
        exp_clear_q.push_back(8'h08);
        exp_data_q.push_back(8'h83);
        do_ack(1'b0, 3'd0);
        bus.irr = 8'h00;
        sample();
        check("aeoi_isr", bus.isr, 8'h00);
        step();
        bus.auto_eoi    = 1'b0;
        bus.auto_rotate = 1'b0;
        bus.irr         = 8'h11;
        step();
        exp_clear_q.push_back(8'h10);
        exp_data_q.push_back(8'h84);
        do_ack(1'b0, 3'd0);
        bus.irr = 8'h01;
        sample();
        check("rotated_isr", bus.isr, 8'h10);
        step();
        step();
        sample();
        check("rotated_ir0_blocked", 8'(bus.int_out), 8'h00);
        step();
        pulse_eoi(1'b0, 3'd0);
        sample();
        check("nonspecific_eoi_isr", bus.isr, 8'h00);
        step();
        bus.irr = 8'h00;
        pulse_rot(3'd7);

        // Spurious acknowledge: request drops before INTA.
        bus.irr = 8'h02;
        step();
        step();
        bus.irr = 8'h00;
        step();
        step();
        sample();
        check("spur_int_low", 8'(bus.int_out), 8'h00);
        exp_data_q.push_back(8'h87);
        step();
        do_ack(1'b0, 3'd0);
        sample();
        check("spur_isr", bus.isr, 8'h00);

        // Poll with IR6 pending, then poll with nothing pending.
        step();
        bus.irr = 8'h40;
        step();
        step();
        exp_data_q.push_back(8'h86);
        exp_clear_q.push_back(8'h40);
        do_poll();
        bus.irr = 8'h00;
        step();
        sample();
        check("poll_isr", bus.isr, 8'h40);
        step();
        exp_data_q.push_back(8'h00);
        do_poll();
        step();
        sample();
        check("poll_empty_isr", bus.isr, 8'h40);
        step();
        pulse_eoi(1'b0, 3'd0);
        sample();
        check("poll_eoi_isr", bus.isr, 8'h00);

        // Specific EOI of IR2 in the same cycle the ack sets IR5.
        step();
        pulse_rot(3'd4);
        bus.irr = 8'h04;
        step();
        exp_clear_q.push_back(8'h04);
        exp_data_q.push_back(8'h82);
        do_ack(1'b0, 3'd0);
        bus.irr = 8'h00;
        sample();
        check("conc_setup_isr", bus.isr, 8'h04);
        step();
        bus.irr = 8'h20;
        step();
        exp_clear_q.push_back(8'h20);
        exp_data_q.push_back(8'h85);
        do_ack(1'b1, 3'd2);
        bus.irr = 8'h00;
        sample();
        check("eoi_vs_ack_isr", bus.isr, 8'h20);

        // Reset while in ACK2.
        step();
        pulse_eoi(1'b0, 3'd0);
        sample();
        check("conc_cleanup_isr", bus.isr, 8'h00);
        step();
        pulse_rot(3'd7);
        bus.irr = 8'h01;
        step();
        exp_clear_q.push_back(8'h01);
        exp_data_q.push_back(8'h80);
        phase(1'b0);
        phase(1'b1);
        bus.inta_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 * PHASE; i++) begin
            sample();
            if (bus.data_oe) begin
                seen = 1'b1;
                break;
            end
        end
        check("ack2_reached", 8'(seen), 8'h01);
        step();
        reset      = 1'b1;
        bus.inta_n = 1'b1;
        bus.irr    = 8'h00;
        step();
        sample();
        check("rst_int_out",   8'(bus.int_out), 8'h00);
        check("rst_isr",       bus.isr,         8'h00);
        check("rst_clear_irr", bus.clear_irr,   8'h00);
        check("rst_data_out",  bus.data_out,    8'h00);
        check("rst_data_oe",   8'(bus.data_oe), 8'h00);
        step();
        reset = 1'b0;
        repeat (5) step();
        sample();
        check("sb_data_drain",  8'(exp_data_q.size()),  8'h00);
        check("sb_clear_drain", 8'(exp_clear_q.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pic_ack_sequencer.md
# pic_ack_sequencer

Synchronous interrupt-acknowledge sequencer and priority arbiter for the 8259A-compatible PIC, 8086 mode only. It sits between the request-detection logic (IRR), the mask and command registers, and the data bus buffer. It arbitrates pending requests under fixed or rotating priority, drives `int_out`, runs the two-pulse INTA sequence and the OCW3 poll sequence, and owns the in-service register (ISR), including normal, specific and automatic EOI.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for `inta_n`, minimum 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inta_n`  in  1  asynchronous external acknowledge, active low; synchronized internally.
- `irr`  in  8  pending requests from the detection logic.
- `imr`  in  8  interrupt mask, 1 = masked.
- `special_mask_mode`  in  1  ISR bits that are masked do not inhibit lower levels.
- `auto_eoi`  in  1  clear the ISR bit at the end of the acknowledge sequence.
- `auto_rotate`  in  1  rotate priority on every AEOI/ack end.
- `vector_base`  in  5  T7–T3 from ICW2.
- `eoi_valid`  in  1  one-cycle OCW2 EOI strobe.
- `eoi_specific`  in  1  qualifies `eoi_valid`: 1 = specific, 0 = non-specific.
- `eoi_level`  in  3  level used for a specific EOI.
- `rot_valid`  in  1  one-cycle set-priority strobe.
- `rot_level`  in  3  new lowest-priority level.
- `poll_cmd`  in  1  one-cycle OCW3 P=1 strobe.
- `poll_read`  in  1  one-cycle strobe marking the end of the read that follows the poll command.
- `int_out`  out  1  interrupt request to CPU.
- `isr`  out  8  in-service register.
- `clear_irr`  out  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit.
- `data_out`  out  8  vector or poll word.
- `data_oe`  out  1  drive enable for `data_out`.

## Operation
- Priority state:
  - `lowest` is 3 bits, reset to 7, so IR0 is highest.
  - Priority order runs from `lowest+1` to `lowest`, mod 8.
- Candidate selection:
  - Candidate set is `irr & ~imr`.
  - The winner is the highest-priority candidate whose priority is strictly above the highest-priority ISR bit.
  - In special mask mode, ISR bits set in `imr` are ignored for this comparison.
- State machine states: IDLE, ACK1, ACK1_HI, ACK2, POLL.
- IDLE:
  - `int_out` = winner exists.
  - Synced falling edge of `inta_n` → latch `ack_level` = winner, set `isr[ack_level]`, pulse `clear_irr`, go to ACK1.
  - If there is no winner, the acknowledge is spurious: `ack_level`=7, ISR and IRR untouched, go to ACK1.
  - `poll_cmd` → go to POLL.
- ACK1: `data_oe`=0; synced rising edge of `inta_n` → ACK1_HI.
- ACK1_HI: synced falling edge → ACK2.
- ACK2:
  - `data_oe`=1 and `data_out`={`vector_base`, `ack_level`} while in this state.
  - Synced rising edge → IDLE.
  - If `auto_eoi`, clear `isr[ack_level]` in the same cycle, except on a spurious acknowledge.
  - If `auto_rotate` and `auto_eoi`, set `lowest`=`ack_level`.
- POLL:
  - Arbitration is frozen at entry; `int_out`=0.
  - While `poll_read` is low, `data_oe`=0.
  - On the `poll_read` cycle, `data_oe`=1 and `data_out`={valid, 4'b0, level}.
  - In that same cycle, if valid: set ISR, pulse `clear_irr`. Then go to IDLE.
- EOI is accepted in any state:
  - Non-specific EOI clears the highest-priority ISR bit.
  - Specific EOI clears `isr[eoi_level]`.
  - With `auto_rotate`, a non-specific EOI also sets `lowest` to the cleared level.
- `rot_valid` sets `lowest`=`rot_level` in any state.
- Simultaneous events:
  - ISR next = (isr | set) & ~clear. A clear wins only for the same bit in the same cycle.
  - If `rot_valid` and an automatic rotation occur together, `rot_valid` wins.
  - In IDLE, if `poll_cmd` and an INTA falling edge arrive together, INTA wins and `poll_cmd` is dropped.

## Timing
- Reset values:
  - `int_out`=0, `isr`=0, `clear_irr`=0, `data_out`=0, `data_oe`=0.
  - State = IDLE, `lowest`=7; synchronizer flops = 1.
- `int_out` is registered: 1 cycle from an `irr`/`imr`/`isr` change.
- `inta_n` edges are seen `SYNC_STAGES`+1 cycles after the pin changes. Each INTA low or high phase must be at least `SYNC_STAGES`+2 cycles.
- `clear_irr` is high for exactly 1 cycle, in the cycle after the detected edge; ISR updates in the same cycle.
- `data_oe` rises 1 cycle after the second detected falling edge and falls 1 cycle after the detected rising edge.
- Reset mid-sequence aborts immediately; no EOI or rotation is applied.

## Structure
- Shared package `pic_pkg` holds:
  - the state enum `ack_state_t`;
  - the constant `PIC_SPURIOUS_LEVEL` = 3'd7;
  - functions `rotate_right8`, `rotate_left8`, `onehot_to_level`, `level_to_onehot`.
- One combinational sub-module, `pic_priority_resolver`. Inputs: `req`, `isr_eff`, `lowest`. Outputs: `valid`, `level`. It is instantiated twice, once for the winner and once for the highest ISR bit.

## Test plan
- Basic acknowledge: reset, `irr`=8'h24, `imr`=0, `vector_base`=5'h10, two INTA pulses → `int_out`=1; `isr`=8'h04; `clear_irr`=8'h04 one cycle; `data_out`=8'h82 with `data_oe` in ACK2.
- Nesting:
  - `isr`=8'h04, `irr`=8'h10 → `int_out` stays 0.
  - Raise `irr[1]` → `int_out`=1 next cycle.
  - Special mask mode with `imr`=8'h04 → IR4 also wins.
- AEOI plus rotate: `auto_eoi`=`auto_rotate`=1, acknowledge IR3 → `isr`=0 after the second rising edge; `lowest`=3; a later simultaneous `irr`=8'h11 picks IR4.
- Spurious acknowledge: `irr` drops before the first INTA → vector {base, 3'd7}; `isr` unchanged; `clear_irr`=0.
- Poll: `irr`=8'h40, `poll_cmd`, then `poll_read` → `data_out`=8'h86; `isr`=8'h40. With `irr`=0 → `data_out`=8'h00 and `isr` unchanged.
- Concurrency and reset: specific EOI for level 2 in the same cycle as the ack setting IR5 → `isr`=8'h20. Reset asserted in ACK2 → all outputs are at reset values next cycle.
